// File: rtl/qsn_issue_ctrl_len3.sv
// qsn_issue_ctrl_len3: column feeder for the length-3 QSN.
// Takes one circulant column per valid/ready transfer and buffers it in a
// 2-entry FIFO. On issue it transposes the messages into bit-planes and
// decodes the shift into QSN selectors. Issue is gated by downstream credits,
// and a valid/col/last tag is delay-matched to the QSN output.
// Optional macro QSN_ISSUE_SHIFT_CHK_EN: flag in_shift=3 on issue (sticky shift_err).
module qsn_issue_ctrl_len3 #(
   parameter int unsigned QSN_LAT = 2,
   parameter int unsigned CREDITS = 4,
   parameter int unsigned COL_W   = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_msg0,
   input  logic [2:0]       in_msg1,
   input  logic [2:0]       in_msg2,
   input  logic [1:0]       in_shift,
   input  logic             in_last,
   output logic [2:0]       sw_in_bit0,
   output logic [2:0]       sw_in_bit1,
   output logic [2:0]       sw_in_bit2,
   output logic [1:0]       left_sel,
   output logic [1:0]       right_sel,
   output logic [1:0]       merge_sel,
   output logic             qsn_out_valid,
   output logic [COL_W-1:0] qsn_out_col,
   output logic             qsn_out_last,
   input  logic             credit_ret,
   output logic             layer_done,
   output logic             shift_err
);

   localparam int unsigned CRD_W = $clog2(CREDITS + 1);
   localparam int unsigned DEPTH = 2;

   typedef struct packed {
      logic [2:0] msg2;
      logic [2:0] msg1;
      logic [2:0] msg0;
      logic [1:0] shift;
      logic       last;
   } col_t;

   typedef struct packed {
      logic             vld;
      logic [COL_W-1:0] col;
      logic             last;
   } tag_t;

   col_t             mem [DEPTH];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic [1:0]       count_nxt;
   logic [CRD_W-1:0] credit;
   logic [COL_W-1:0] col_cnt;
   tag_t             tag_pipe [QSN_LAT+1];

   col_t       head;
   logic       push_c;
   logic       issue_c;
   logic [1:0] s_eff;
   logic [1:0] l_dec;
   logic [1:0] m_dec;

   assign head    = mem[rd_ptr];
   assign push_c  = in_valid && in_ready;
   assign issue_c = (count != 2'd0) && (credit != '0);

   // FIFO occupancy after this cycle's push/pop
   always_comb begin
      count_nxt = count;
      if (push_c && !issue_c) begin
         count_nxt = count + 2'd1;
      end else if (!push_c && issue_c) begin
         count_nxt = count - 2'd1;
      end
   end

   // Shift decode; an out-of-range shift of 3 falls back to s=0
   always_comb begin
      l_dec = 2'd0;
      m_dec = 2'b00;
      s_eff = head.shift;
      if (head.shift == 2'd3) begin
         s_eff = 2'd0;
      end
      case (s_eff)
         2'd1:    begin l_dec = 2'd2; m_dec = 2'b01; end
         2'd2:    begin l_dec = 2'd1; m_dec = 2'b11; end
         default: begin l_dec = 2'd0; m_dec = 2'b00; end
      endcase
   end

   // FIFO storage write; contents are don't-care until pushed
   always_ff @(posedge sys_clk) begin
      if (push_c) begin
         mem[wr_ptr] <= {in_msg2, in_msg1, in_msg0, in_shift, in_last};
      end
   end

   // Pointers, credits, column counter, issue outputs and tag delay line
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count      <= 2'd0;
         in_ready   <= 1'b0;
         credit     <= CRD_W'(CREDITS);
         col_cnt    <= '0;
         sw_in_bit0 <= 3'd0;
         sw_in_bit1 <= 3'd0;
         sw_in_bit2 <= 3'd0;
         left_sel   <= 2'd0;
         right_sel  <= 2'd0;
         merge_sel  <= 2'd0;
         layer_done <= 1'b0;
         for (int unsigned i = 0; i <= QSN_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         if (push_c) begin
            wr_ptr <= ~wr_ptr;
         end
         if (issue_c) begin
            rd_ptr <= ~rd_ptr;
         end
         count    <= count_nxt;
         in_ready <= (count_nxt < 2'd2);

         if (issue_c && !credit_ret) begin
            credit <= credit - CRD_W'(1);
         end else if (!issue_c && credit_ret && (credit != CRD_W'(CREDITS))) begin
            credit <= credit + CRD_W'(1);
         end

         if (issue_c) begin
            col_cnt    <= head.last ? '0 : COL_W'(col_cnt + 1'b1);
            sw_in_bit0 <= {head.msg2[0], head.msg1[0], head.msg0[0]};
            sw_in_bit1 <= {head.msg2[1], head.msg1[1], head.msg0[1]};
            sw_in_bit2 <= {head.msg2[2], head.msg1[2], head.msg0[2]};
            right_sel  <= s_eff;
            left_sel   <= l_dec;
            merge_sel  <= m_dec;
         end

         tag_pipe[0].vld  <= issue_c;
         tag_pipe[0].col  <= issue_c ? col_cnt : '0;
         tag_pipe[0].last <= issue_c && head.last;
         for (int unsigned i = 1; i <= QSN_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
         layer_done <= tag_pipe[QSN_LAT-1].vld && tag_pipe[QSN_LAT-1].last;
      end
   end

   assign qsn_out_valid = tag_pipe[QSN_LAT].vld;
   assign qsn_out_col   = tag_pipe[QSN_LAT].col;
   assign qsn_out_last  = tag_pipe[QSN_LAT].last;

`ifdef QSN_ISSUE_SHIFT_CHK_EN
   // Sticky flag for an illegal shift seen on an issued column
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_err <= 1'b0;
      end else if (issue_c && (head.shift == 2'd3)) begin
         shift_err <= 1'b1;
      end
   end
`else
   assign shift_err = 1'b0;
`endif

endmodule

// File: tb/tb_qsn_issue_ctrl_len3.sv
// Bench for qsn_issue_ctrl_len3: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a queue-based model.
module tb_qsn_issue_ctrl_len3;

   localparam int unsigned QSN_LAT = 2;
   localparam int unsigned CREDITS = 4;
   localparam int unsigned COL_W   = 4;
`ifdef QSN_ISSUE_SHIFT_CHK_EN
   localparam bit EXP_ERR = 1'b1;
`else
   localparam bit EXP_ERR = 1'b0;
`endif

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_msg0, in_msg1, in_msg2;
   logic [1:0]       in_shift;
   logic             in_last;
   logic [2:0]       sw_in_bit0, sw_in_bit1, sw_in_bit2;
   logic [1:0]       left_sel, right_sel, merge_sel;
   logic             qsn_out_valid;
   logic [COL_W-1:0] qsn_out_col;
   logic             qsn_out_last;
   logic             credit_ret;
   logic             layer_done;
   logic             shift_err;

   qsn_issue_ctrl_len3 #(.QSN_LAT(QSN_LAT), .CREDITS(CREDITS), .COL_W(COL_W)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_msg0(in_msg0), .in_msg1(in_msg1), .in_msg2(in_msg2),
      .in_shift(in_shift), .in_last(in_last),
      .sw_in_bit0(sw_in_bit0), .sw_in_bit1(sw_in_bit1), .sw_in_bit2(sw_in_bit2),
      .left_sel(left_sel), .right_sel(right_sel), .merge_sel(merge_sel),
      .qsn_out_valid(qsn_out_valid), .qsn_out_col(qsn_out_col), .qsn_out_last(qsn_out_last),
      .credit_ret(credit_ret), .layer_done(layer_done), .shift_err(shift_err)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [2:0] m2;
      logic [2:0] m1;
      logic [2:0] m0;
      logic [1:0] sh;
      logic       lst;
   } col_t;

   typedef struct packed {
      logic [COL_W-1:0] col;
      logic             lst;
   } tag_t;

   col_t       mq[$];
   tag_t       pend[int];
   int         cyc = 0;
   int         m_credit = 0;
   int         m_col = 0;
   int         m_s = 0;
   bit         m_rdy = 0;
   bit         m_push, m_iss;
   col_t       m_h;
   logic [2:0] m_b0 = 0, m_b1 = 0, m_b2 = 0;
   logic [1:0] m_r = 0, m_l = 0, m_m = 0;
   bit         m_err = 0;
   bit         m_ov = 0, m_last = 0;
   logic [COL_W-1:0] m_ocol = 0;

   // Model update on each rising edge from the inputs held across it
   always @(posedge sys_clk) begin
      cyc++;
      if (sys_rst) begin
         mq.delete();
         pend.delete();
         m_credit = CREDITS;
         m_col = 0;
         m_rdy = 0;
         {m_b0, m_b1, m_b2, m_r, m_l, m_m} = '0;
         m_err = 0;
         m_ov = 0;
         m_last = 0;
      end else begin
         m_push = in_valid && m_rdy;
         m_iss  = (mq.size() > 0) && (m_credit > 0);
         if (m_iss) begin
            m_h = mq.pop_front();
            m_s = (m_h.sh == 2'd3) ? 0 : int'(m_h.sh);
            if (m_h.sh == 2'd3) m_err = EXP_ERR;
            m_b0 = {m_h.m2[0], m_h.m1[0], m_h.m0[0]};
            m_b1 = {m_h.m2[1], m_h.m1[1], m_h.m0[1]};
            m_b2 = {m_h.m2[2], m_h.m1[2], m_h.m0[2]};
            m_r  = 2'(m_s);
            m_l  = 2'((3 - m_s) % 3);
            m_m  = (m_s == 0) ? 2'b00 : (m_s == 1) ? 2'b01 : 2'b11;
            pend[cyc + QSN_LAT] = '{col: COL_W'(m_col), lst: m_h.lst};
            m_col = m_h.lst ? 0 : (m_col + 1) % (1 << COL_W);
         end
         if (m_iss && credit_ret) ;
         else if (m_iss) m_credit--;
         else if (credit_ret && m_credit < CREDITS) m_credit++;
         if (m_push) mq.push_back({in_msg2, in_msg1, in_msg0, in_shift, in_last});
         m_rdy = (mq.size() < 2);
         if (pend.exists(cyc)) begin
            m_ov = 1;
            m_ocol = pend[cyc].col;
            m_last = pend[cyc].lst;
            pend.delete(cyc);
         end else begin
            m_ov = 0;
            m_last = 0;
         end
      end
   end

   bit chk_en = 0;

   // Whole-output comparison against the model, away from the active edge
   always @(negedge sys_clk) begin
      if (chk_en) begin
         check("m_ready", 32'(in_ready), 32'(m_rdy));
         check("m_out_valid", 32'(qsn_out_valid), 32'(m_ov));
         if (m_ov) begin
            check("m_out_col", 32'(qsn_out_col), 32'(m_ocol));
            check("m_out_last", 32'(qsn_out_last), 32'(m_last));
         end
         check("m_layer_done", 32'(layer_done), 32'(m_ov && m_last));
         check("m_bits", 32'({sw_in_bit2, sw_in_bit1, sw_in_bit0}), 32'({m_b2, m_b1, m_b0}));
         check("m_sels", 32'({left_sel, right_sel, merge_sel}), 32'({m_l, m_r, m_m}));
         check("m_shift_err", 32'(shift_err), 32'(m_err));
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct packed {
      logic       rst, vld;
      logic [2:0] m0, m1, m2;
      logic [1:0] sh;
      logic       lst;
      logic       e_rdy, e_ov;
      logic [3:0] e_col;
      logic       e_last, e_ld;
      logic       chk_sw;
      logic [2:0] e_b0, e_b1, e_b2;
      logic [1:0] e_r, e_l, e_m;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(input logic rst, input logic vld, input logic [2:0] m0,
                                input logic [2:0] m1, input logic [2:0] m2, input logic [1:0] sh,
                                input logic lst, input logic e_rdy, input logic e_ov,
                                input logic [3:0] e_col, input logic e_last, input logic e_ld);
      vec_t v;
      v = '0;
      v.rst = rst; v.vld = vld; v.m0 = m0; v.m1 = m1; v.m2 = m2; v.sh = sh; v.lst = lst;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_col = e_col; v.e_last = e_last; v.e_ld = e_ld;
      return v;
   endfunction

   task automatic drive(input logic vld, input logic [1:0] sh, input logic lst, input logic ret);
      in_valid = vld;
      in_msg0 = 3'($urandom_range(0, 7));
      in_msg1 = 3'($urandom_range(0, 7));
      in_msg2 = 3'($urandom_range(0, 7));
      in_shift = sh;
      in_last = lst;
      credit_ret = ret;
   endtask

   task automatic do_reset();
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
   endtask

   // Offer columns until n are accepted (bounded); counts QSN outputs seen
   task automatic stream(input int n, output int acc, inout int nv);
      int guard;
      acc = 0;
      guard = 0;
      while (acc < n && guard < 40) begin
         drive(1'b1, 2'($urandom_range(0, 2)), 1'b0, 1'b0);
         if (in_ready) acc++;
         @(negedge sys_clk);
         if (qsn_out_valid) nv++;
         guard++;
      end
      drive(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic count_valid(input int cycles, inout int nv);
      for (int k = 0; k < cycles; k++) begin
         @(negedge sys_clk);
         if (qsn_out_valid) nv++;
      end
   endtask

   int acc, nv, rp;

   initial begin
      sys_rst = 1'b1;
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk_en = 1;
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(qsn_out_valid), 32'd0);
      check("rst_sels", 32'({left_sel, right_sel, merge_sel}), 32'd0);

      // single column, then a 4-column layer-wrap sequence
      tbl.push_back(mkv(1, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 1, 3'b101, 3'b010, 3'b111, 2'd1, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl[3].chk_sw = 1; tbl[3].e_b0 = 3'b101; tbl[3].e_b1 = 3'b110; tbl[3].e_b2 = 3'b101;
      tbl[3].e_r = 2'b01; tbl[3].e_l = 2'b10; tbl[3].e_m = 2'b01;
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 1, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(1, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 1, 3'b001, 3'b010, 3'b011, 2'd0, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 1, 3'b100, 3'b101, 3'b110, 2'd2, 0, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 1, 3'b111, 3'b000, 3'b001, 2'd1, 1, 1, 0, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 1, 3'b010, 3'b011, 3'b100, 2'd0, 0, 1, 1, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 1, 4'd1, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 1, 4'd2, 1, 1));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 1, 4'd0, 0, 0));
      tbl.push_back(mkv(0, 0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 1, 0, 4'd0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         sys_rst = tbl[i].rst; in_valid = tbl[i].vld;
         in_msg0 = tbl[i].m0; in_msg1 = tbl[i].m1; in_msg2 = tbl[i].m2;
         in_shift = tbl[i].sh; in_last = tbl[i].lst; credit_ret = 1'b0;
         @(negedge sys_clk);
         check($sformatf("t%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         check($sformatf("t%0d_out_valid", i), 32'(qsn_out_valid), 32'(tbl[i].e_ov));
         check($sformatf("t%0d_layer_done", i), 32'(layer_done), 32'(tbl[i].e_ld));
         if (tbl[i].e_ov) begin
            check($sformatf("t%0d_out_col", i), 32'(qsn_out_col), 32'(tbl[i].e_col));
            check($sformatf("t%0d_out_last", i), 32'(qsn_out_last), 32'(tbl[i].e_last));
         end
         if (tbl[i].chk_sw) begin
            check($sformatf("t%0d_bits", i), 32'({sw_in_bit2, sw_in_bit1, sw_in_bit0}),
                  32'({tbl[i].e_b2, tbl[i].e_b1, tbl[i].e_b0}));
            check($sformatf("t%0d_sels", i), 32'({left_sel, right_sel, merge_sel}),
                  32'({tbl[i].e_l, tbl[i].e_r, tbl[i].e_m}));
         end
      end
      sys_rst = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 1'b0);

      // credit exhaustion: 6 accepted, 4 issued, FIFO left full
      do_reset();
      check("post_rst_ready", 32'(in_ready), 32'd1);
      nv = 0;
      stream(6, acc, nv);
      check("stream_accepted", 32'(acc), 32'd6);
      count_valid(10, nv);
      check("stream_issues", 32'(nv), 32'd4);
      check("stall_ready", 32'(in_ready), 32'd0);

      // two credit returns release exactly two columns
      nv = 0;
      drive(1'b0, 2'd0, 1'b0, 1'b1);
      count_valid(2, nv);
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      count_valid(10, nv);
      check("ret_issues", 32'(nv), 32'd2);
      check("ret_ready", 32'(in_ready), 32'd1);
      nv = 0;
      drive(1'b1, 2'd0, 1'b0, 1'b0);
      count_valid(1, nv);
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      count_valid(8, nv);
      check("no_credit_issue", 32'(nv), 32'd0);

      // reset while two columns sit in the delay line
      do_reset();
      drive(1'b1, 2'd1, 1'b0, 1'b0);
      @(negedge sys_clk);
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      @(negedge sys_clk);
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      check("midrst_ready", 32'(in_ready), 32'd0);
      sys_rst = 1'b0;
      nv = qsn_out_valid ? 1 : 0;
      @(negedge sys_clk);
      check("midrst_after_ready", 32'(in_ready), 32'd1);
      if (qsn_out_valid) nv++;
      count_valid(8, nv);
      check("midrst_no_valid", 32'(nv), 32'd0);
      nv = 0;
      stream(5, acc, nv);
      count_valid(10, nv);
      check("midrst_credit4", 32'(nv), 32'd4);

      // illegal shift followed by legal columns
      do_reset();
      drive(1'b1, 2'd1, 1'b0, 1'b0);
      @(negedge sys_clk);
      drive(1'b1, 2'd3, 1'b0, 1'b0);
      @(negedge sys_clk);
      check("sh1_sels", 32'({left_sel, right_sel, merge_sel}), 32'({2'd2, 2'd1, 2'b01}));
      drive(1'b1, 2'd2, 1'b0, 1'b0);
      @(negedge sys_clk);
      check("sh3_sels", 32'({left_sel, right_sel, merge_sel}), 32'd0);
      check("sh3_err", 32'(shift_err), 32'(EXP_ERR));
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      @(negedge sys_clk);
      check("sh2_sels", 32'({left_sel, right_sel, merge_sel}), 32'({2'd1, 2'd2, 2'b11}));
      check("sh_err_held", 32'(shift_err), 32'(EXP_ERR));

      // random traffic with varying credit-return pressure
      for (int c = 0; c < 3000; c++) begin
         rp = (c / 500) % 3;
         sys_rst = ($urandom_range(0, 249) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_msg0 = 3'($urandom_range(0, 7));
         in_msg1 = 3'($urandom_range(0, 7));
         in_msg2 = 3'($urandom_range(0, 7));
         in_shift = 2'($urandom_range(0, 3));
         in_last = ($urandom_range(0, 4) == 0);
         credit_ret = ($urandom_range(0, 3) < rp + 1) && ($urandom_range(0, 1) == 0);
         @(negedge sys_clk);
      end
      sys_rst = 1'b0;
      drive(1'b0, 2'd0, 1'b0, 1'b0);
      repeat (6) @(negedge sys_clk);
      chk_en = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
